// File: rtl/encoder_16to4_stream.sv
// -----------------------------------------------------------------------------
// encoder_16to4_stream
//
// Sequential 16-to-4 encoder. A 16-bit request vector is accepted over a
// valid/ready handshake, then the index of every set bit is emitted, one index
// per output beat, with a last flag on the final beat. An all-zero vector
// yields a single beat flagged with out_zero.
//
// Build option:
//   ENCODER_MSB_FIRST_EN  defined   -> highest set bit is emitted first
//                         undefined -> lowest set bit is emitted first
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_vec     in  16   request vector
//   in_valid   in   1   in_vec valid
//   in_ready   out  1   block can accept a vector (IDLE)
//   out_idx    out  4   index of the current set bit
//   out_valid  out  1   out_idx / flags valid (BUSY)
//   out_ready  in   1   consumer accepts the current beat
//   out_last   out  1   current beat is the final beat of this vector
//   out_zero   out  1   accepted vector was all zeros
//   out_count  out  5   population count of the accepted vector
// -----------------------------------------------------------------------------
module encoder_16to4_stream (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in_vec,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [3:0]  out_idx,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        out_zero,
   output logic [4:0]  out_count
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state;
   logic [15:0] pending;
   logic        zero_r;
   logic [4:0]  count_r;

   logic        busy;
   logic [3:0]  sel_idx;
   logic        single_bit;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [3:0] highest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign busy = (state == BUSY);

   // Index selection looks only at the pending register, so nothing on the
   // input side can reach the outputs combinationally. pending is zero for a
   // zero vector, which makes both scan functions return 0 there.
`ifdef ENCODER_MSB_FIRST_EN
   assign sel_idx = highest_idx(pending);
`else
   assign sel_idx = lowest_idx(pending);
`endif

   // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing.
   assign single_bit = (pending != 16'd0) && ((pending & (pending - 16'd1)) == 16'd0);

   assign in_ready  = ~busy;
   assign out_valid = busy;
   assign out_idx   = busy ? sel_idx : 4'd0;
   assign out_last  = busy & (zero_r | single_bit);
   assign out_zero  = busy & zero_r;
   assign out_count = busy ? count_r : 5'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
         zero_r  <= 1'b0;
         count_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pending <= in_vec;
                  count_r <= popcount16(in_vec);
                  zero_r  <= (in_vec == 16'd0);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (out_ready) begin
                  pending <= pending & ~(16'd1 << sel_idx);
                  // No same-cycle reload: in_ready only rises once IDLE is
                  // reached on the following cycle.
                  if (out_last) begin
                     state  <= IDLE;
                     zero_r <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_16to4_stream.sv
`timescale 1ns/1ps
module tb_encoder_16to4_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_vec;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  out_idx;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        out_zero;
   logic [4:0]  out_count;

   always #5 clk = ~clk;

   encoder_16to4_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vec    (in_vec),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_zero  (out_zero),
      .out_count (out_count)
   );

   typedef struct {
      logic [3:0] idx;
      logic       last;
      logic       zero;
      logic [4:0] count;
   } beat_t;

   typedef struct {
      logic [15:0] vec;
      logic [4:0]  count;
      int          beats;
   } vec_rec_t;

   beat_t sb[$];
   int    nchk   = 0;
   int    nfail  = 0;
   int    nbeats = 0;
   logic  stalled = 1'b0;
   beat_t hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference beat sequence for a vector; out_count comes from the table.
   task automatic push_model(input logic [15:0] vec, input logic [4:0] cnt);
      int n;
      int i;
      beat_t b;
      n = 0;
      for (int k = 0; k < 16; k++) if (vec[k]) n++;
      if (vec == 16'd0) begin
         b = '{idx: 4'd0, last: 1'b1, zero: 1'b1, count: 5'd0};
         sb.push_back(b);
      end else begin
         for (int k = 0; k < 16; k++) begin
`ifdef ENCODER_MSB_FIRST_EN
            i = 15 - k;
`else
            i = k;
`endif
            if (vec[i]) begin
               n--;
               b = '{idx: 4'(i), last: (n == 0), zero: 1'b0, count: cnt};
               sb.push_back(b);
            end
         end
      end
   endtask

   // Monitor / scoreboard: sampled on the falling edge.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && out_valid) begin
         if (stalled) begin
            chk("stall_idx",   out_idx,   hold.idx);
            chk("stall_last",  out_last,  hold.last);
            chk("stall_zero",  out_zero,  hold.zero);
            chk("stall_count", out_count, hold.count);
         end
         if (out_ready) begin
            stalled = 1'b0;
            if (sb.size() == 0) begin
               nchk++;
               nfail++;
               $display("FAIL unexpected_beat: got idx %0d with no beat expected", out_idx);
            end else begin
               e = sb.pop_front();
               chk("out_idx",   out_idx,   e.idx);
               chk("out_last",  out_last,  e.last);
               chk("out_zero",  out_zero,  e.zero);
               chk("out_count", out_count, e.count);
               nbeats++;
            end
         end else begin
            stalled   = 1'b1;
            hold.idx   = out_idx;
            hold.last  = out_last;
            hold.zero  = out_zero;
            hold.count = out_count;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic send(input logic [15:0] vec, input logic [4:0] cnt);
      for (int t = 0; t < 50 && !in_ready; t++) begin
         @(posedge clk);
         #1;
      end
      chk("in_ready_before_send", in_ready, 1'b1);
      nbeats   = 0;
      in_vec   = vec;
      in_valid = 1'b1;
      push_model(vec, cnt);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_vec   = 16'($urandom);
      chk("first_beat_valid", out_valid, 1'b1);
      chk("busy_in_ready",    in_ready,  1'b0);
   endtask

   task automatic drain(input int exp_beats);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", sb.size(), 0);
      chk("beat_total",  nbeats,    exp_beats);
      @(posedge clk);
      #1;
      chk("turnaround_in_ready", in_ready,  1'b1);
      chk("turnaround_idle",     out_valid, 1'b0);
   endtask

   vec_rec_t tbl[8];

   initial begin
      tbl[0] = '{vec: 16'h0001, count: 5'd1,  beats: 1};
      tbl[1] = '{vec: 16'h8421, count: 5'd4,  beats: 4};
      tbl[2] = '{vec: 16'h0000, count: 5'd0,  beats: 1};
      tbl[3] = '{vec: 16'h8000, count: 5'd1,  beats: 1};
      tbl[4] = '{vec: 16'h0003, count: 5'd2,  beats: 2};
      tbl[5] = '{vec: 16'hA5A5, count: 5'd8,  beats: 8};
      tbl[6] = '{vec: 16'hFFFF, count: 5'd16, beats: 16};
      tbl[7] = '{vec: 16'h7FFE, count: 5'd14, beats: 14};

      rst_n     = 1'b0;
      in_vec    = 16'h0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_idx",   out_idx,   4'd0);
      chk("rst_out_last",  out_last,  1'b0);
      chk("rst_out_zero",  out_zero,  1'b0);
      chk("rst_out_count", out_count, 5'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);

      // Table-driven vectors with full throughput.
      for (int r = 0; r < 8; r++) begin
         send(tbl[r].vec, tbl[r].count);
         drain(tbl[r].beats);
      end

      // in_valid while BUSY must not disturb the burst.
      send(16'h8421, 5'd4);
      in_vec   = 16'hFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain(4);

      // Backpressure: out_ready alternates 0/1 starting at 0.
      out_ready = 1'b0;
      send(16'hFFFF, 5'd16);
      for (int c = 1; c < 32; c++) begin
         @(posedge clk);
         #1;
         out_ready = ~out_ready;
      end
      @(negedge clk);
      #1;
      chk("bp_queue_empty", sb.size(), 0);
      chk("bp_handshakes",  nbeats,    16);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_turnaround_in_ready", in_ready, 1'b1);

      // Reset mid-burst: 0x00F0, reset after the idx 5 handshake.
      send(16'h00F0, 5'd4);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("mid_before_rst_idx", out_idx, 4'd6);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_in_ready",  in_ready,  1'b1);
      chk("mid_rst_beats",     nbeats,    2);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("after_rst_in_ready", in_ready, 1'b1);
      send(16'h0002, 5'd1);
      drain(1);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
